// File: rtl/steer_quad_decoder.sv
// steer_quad_decoder
//
// Receives a two-phase quadrature steering signal and turns it back into a signed
// position count, one-cycle direction pulses and an illegal-transition indication.
// Everything runs in the CLK domain; quad_a/quad_b are synchronized internally.
//
// Ports
//   CLK       in   system clock (6 MHz video clock)
//   Reset_n   in   synchronous, active-low reset
//   ce        in   sample enable for filter, INIT load and idle timer
//   quad_a    in   phase A, asynchronous
//   quad_b    in   phase B, asynchronous
//   clr       in   synchronous clear of pos and err_cnt
//   pos       out  signed position count, wraps modulo 2^POS_W
//   step_cw   out  one-CLK pulse per accepted clockwise step
//   step_ccw  out  one-CLK pulse per accepted counter-clockwise step
//   dir       out  direction of the last step (1 = CW)
//   err       out  one-CLK pulse on an illegal double transition
//   err_cnt   out  saturating count of illegal transitions
//   moving    out  a step was accepted within the last IDLE_TO ce ticks
module steer_quad_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned POS_W      = 8,
    parameter int unsigned IDLE_TO    = 1023
) (
    input  logic                    CLK,
    input  logic                    Reset_n,
    input  logic                    ce,
    input  logic                    quad_a,
    input  logic                    quad_b,
    input  logic                    clr,
    output logic signed [POS_W-1:0] pos,
    output logic                    step_cw,
    output logic                    step_ccw,
    output logic                    dir,
    output logic                    err,
    output logic [7:0]              err_cnt,
    output logic                    moving
);

    localparam logic [3:0]              FiltLen = 4'(FILTER_LEN);
    localparam logic [9:0]              IdleMax = 10'(IDLE_TO);
    localparam logic signed [POS_W-1:0] PosOne  = POS_W'(1);

    typedef enum logic {StInit, StTrack} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              wait_q, wait_d;
    logic [1:0]              meta_q, meta_d;
    logic [1:0]              sync_q, sync_d;
    logic [1:0]              cand_q, cand_d;
    logic [3:0]              run_q, run_d;
    logic [1:0]              filt_q, filt_d;
    logic [1:0]              prev_q, prev_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    step_cw_q, step_cw_d;
    logic                    step_ccw_q, step_ccw_d;
    logic                    err_q, err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [9:0]              idle_q, idle_d;

    logic       is_cw, is_ccw, is_ill;
    logic [3:0] run_inc;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        meta_d     = {quad_a, quad_b};
        sync_d     = meta_q;
        cand_d     = cand_q;
        run_d      = run_q;
        filt_d     = filt_q;
        // prev trails filt by one cycle so a filt change is decoded on the following edge
        prev_d     = filt_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        err_cnt_d  = err_cnt_q;
        idle_d     = idle_q;
        is_cw      = 1'b0;
        is_ccw     = 1'b0;
        is_ill     = 1'b0;
        run_inc    = 4'd0;

        // Decode the last accepted filt change; codes are {A,B}, CW order 00,10,11,01.
        if (state_q == StTrack && prev_q != filt_q) begin
            case ({prev_q, filt_q})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_cw  = 1'b1;
                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: is_ccw = 1'b1;
                default:                                is_ill = 1'b1;
            endcase
        end

        step_cw_d  = is_cw;
        step_ccw_d = is_ccw;
        err_d      = is_ill;

        if (is_cw) begin
            pos_d = pos_q + PosOne;
            dir_d = 1'b1;
        end
        if (is_ccw) begin
            pos_d = pos_q - PosOne;
            dir_d = 1'b0;
        end
        if (is_ill && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        // clr wins over the count update but the pulses above are still emitted
        if (clr) begin
            pos_d     = '0;
            err_cnt_d = '0;
        end

        if (is_cw || is_ccw) begin
            idle_d = '0;
        end else if (ce && idle_q < IdleMax) begin
            idle_d = idle_q + 10'd1;
        end

        case (state_q)
            StInit: begin
                // Two CLK cycles let the synchronizer fill before the first load.
                if (wait_q != 2'd2) begin
                    wait_d = wait_q + 2'd1;
                end else if (ce) begin
                    filt_d  = sync_q;
                    prev_d  = sync_q;
                    cand_d  = sync_q;
                    run_d   = '0;
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (ce) begin
                    if (sync_q == filt_q) begin
                        run_d = '0;
                    end else begin
                        if (sync_q == cand_q) begin
                            run_inc = run_q + 4'd1;
                        end else begin
                            cand_d  = sync_q;
                            run_inc = 4'd1;
                        end
                        if (run_inc == FiltLen) begin
                            filt_d = sync_q;
                            run_d  = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q    <= StInit;
            wait_q     <= '0;
            meta_q     <= '0;
            sync_q     <= '0;
            cand_q     <= '0;
            run_q      <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            idle_q     <= IdleMax;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            cand_q     <= cand_d;
            run_q      <= run_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            step_cw_q  <= step_cw_d;
            step_ccw_q <= step_ccw_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign pos      = pos_q;
    assign dir      = dir_q;
    assign step_cw  = step_cw_q;
    assign step_ccw = step_ccw_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign moving   = (idle_q < IdleMax);

endmodule

// File: tb/tb_steer_quad_decoder.sv
module tb_steer_quad_decoder;

    localparam int FL = 4;
    localparam int PW = 8;
    localparam int IT = 1023;

    logic                 CLK;
    logic                 Reset_n;
    logic                 ce;
    logic                 quad_a;
    logic                 quad_b;
    logic                 clr;
    logic signed [PW-1:0] pos;
    logic                 step_cw;
    logic                 step_ccw;
    logic                 dir;
    logic                 err;
    logic [7:0]           err_cnt;
    logic                 moving;

    steer_quad_decoder #(
        .FILTER_LEN(FL),
        .POS_W     (PW),
        .IDLE_TO   (IT)
    ) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .ce      (ce),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .clr     (clr),
        .pos     (pos),
        .step_cw (step_cw),
        .step_ccw(step_ccw),
        .dir     (dir),
        .err     (err),
        .err_cnt (err_cnt),
        .moving  (moving)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    // Position of each {A,B} code around the CW cycle 00,10,11,01, and the inverse.
    int gidx[4] = '{0, 3, 1, 2};
    int gval[4] = '{0, 2, 3, 1};

    // Behavioural reference state
    int m_d0, m_d1;            // synchronizer delay line
    bit m_init;
    int m_wait;
    int m_filt, m_last, m_run;
    int m_pend;                // quarter-turns of the change accepted last edge (0 = none)
    int m_pos, m_dir, m_errc, m_idle;
    int m_cw, m_ccw, m_err;

    task automatic check(string name, logic signed [31:0] got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d0 = 0; m_d1 = 0;
        m_init = 1'b1; m_wait = 0;
        m_filt = 0; m_last = 0; m_run = 0; m_pend = 0;
        m_pos = 0; m_dir = 0; m_errc = 0; m_idle = IT;
        m_cw = 0; m_ccw = 0; m_err = 0;
    endtask

    // Advance the model across one rising edge using the inputs in force at that edge.
    task automatic model_step();
        int s;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        m_cw  = (m_pend == 1) ? 1 : 0;
        m_ccw = (m_pend == 3) ? 1 : 0;
        m_err = (m_pend == 2) ? 1 : 0;
        if (m_cw == 1)  begin m_pos = ((m_pos + 1 + 384) % 256) - 128; m_dir = 1; end
        if (m_ccw == 1) begin m_pos = ((m_pos - 1 + 384) % 256) - 128; m_dir = 0; end
        if (m_err == 1 && m_errc < 255) m_errc++;
        if (clr) begin m_pos = 0; m_errc = 0; end
        if (m_cw == 1 || m_ccw == 1) m_idle = 0;
        else if (ce && m_idle < IT) m_idle++;

        m_pend = 0;
        s = m_d1;
        if (m_init) begin
            if (m_wait < 2) m_wait++;
            else if (ce) begin
                m_filt = s; m_last = s; m_run = 0; m_init = 1'b0;
            end
        end else if (ce) begin
            // Acceptance needs FL consecutive ce samples of one value that differs from filt.
            if (s == m_filt) m_run = 0;
            else begin
                m_run  = (s == m_last && m_run > 0) ? m_run + 1 : 1;
                m_last = s;
                if (m_run == FL) begin
                    m_pend = (gidx[s] - gidx[m_filt] + 4) % 4;
                    m_filt = s;
                    m_run  = 0;
                end
            end
        end
        m_d1 = m_d0;
        m_d0 = int'({quad_a, quad_b});
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("pos",      32'(pos),      m_pos);
        check("dir",      32'(dir),      m_dir);
        check("step_cw",  32'(step_cw),  m_cw);
        check("step_ccw", 32'(step_ccw), m_ccw);
        check("err",      32'(err),      m_err);
        check("err_cnt",  32'(err_cnt),  m_errc);
        check("moving",   32'(moving),   (m_idle < IT) ? 1 : 0);
    endtask

    task automatic set_ab(int v);
        quad_a = v[1];
        quad_b = v[0];
    endtask

    task automatic do_reset(int v);
        Reset_n = 1'b0;
        set_ab(v);
        repeat (3) tick();
        Reset_n = 1'b1;
        repeat (5) tick();
    endtask

    // Drive a new code and count edges until step_cw rises, bounded.
    task automatic cw_measure(int v, output int n);
        set_ab(v);
        n = 0;
        do begin
            tick();
            n++;
        end while (step_cw !== 1'b1 && n <= 20);
    endtask

    int cur;
    int n;
    int pulses;
    int guard;

    initial begin
        Reset_n = 1'b0; ce = 1'b1; clr = 1'b0;
        quad_a = 1'b1; quad_b = 1'b1;
        model_reset();

        // Reset with 11 present; INIT loads it silently.
        do_reset(3);
        pulses = 0;
        repeat (10) begin
            tick();
            pulses += int'(step_cw) + int'(step_ccw) + int'(err);
        end
        check("init_pulses", pulses, 0);
        check("init_pos", 32'(pos), 0);
        check("init_moving", 32'(moving), 0);

        // Four CW steps from 00, 7-edge latency each.
        do_reset(0);
        cur = 0;
        repeat (4) begin
            cur = (cur + 1) % 4;
            cw_measure(gval[cur], n);
            check("cw_latency", n, 7);
            repeat (8 - n) tick();
        end
        check("cw4_pos", 32'(pos), 4);
        check("cw4_dir", 32'(dir), 1);
        check("cw4_moving", 32'(moving), 1);

        // Two CCW steps (00 -> 01 -> 11), then a 3-cycle glitch to 01.
        set_ab(1); repeat (8) tick();
        set_ab(3); repeat (8) tick();
        pulses = 0;
        set_ab(1); repeat (3) tick();
        pulses += int'(step_cw) + int'(step_ccw) + int'(err);
        set_ab(3);
        repeat (10) begin
            tick();
            pulses += int'(step_cw) + int'(step_ccw) + int'(err);
        end
        check("glitch_pulses", pulses, 0);
        check("ccw_pos", 32'(pos), 2);
        check("ccw_dir", 32'(dir), 0);

        // Illegal 11 -> 00, then 300 more illegal transitions to saturate err_cnt.
        pulses = 0;
        set_ab(0);
        repeat (8) begin
            tick();
            pulses += int'(err);
        end
        check("ill_err_pulses", pulses, 1);
        check("ill_err_cnt", 32'(err_cnt), 1);
        check("ill_pos", 32'(pos), 2);
        for (int i = 0; i < 300; i++) begin
            set_ab((i % 2 == 0) ? 3 : 0);
            repeat (8) tick();
        end
        check("sat_err_cnt", 32'(err_cnt), 255);
        check("sat_pos", 32'(pos), 2);

        // CW up to 127, then wrap to -128.
        cur = 0;
        guard = 0;
        while (m_pos != 127 && guard < 300) begin
            cur = (cur + 1) % 4;
            set_ab(gval[cur]);
            repeat (8) tick();
            guard++;
        end
        check("pos_max", 32'(pos), 127);
        cur = (cur + 1) % 4;
        set_ab(gval[cur]);
        repeat (8) tick();
        check("pos_wrap", 32'(pos), -128);

        // clr in the same cycle the CW pulse lands.
        cur = (cur + 1) % 4;
        set_ab(gval[cur]);
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_step_cw", 32'(step_cw), 1);
        check("clr_pos", 32'(pos), 0);
        repeat (4) tick();

        // ce high one cycle in four while stepping.
        for (int s = 0; s < 4; s++) begin
            cur = (cur + 1) % 4;
            set_ab(gval[cur]);
            for (int k = 0; k < 40; k++) begin
                ce = (k % 4 == 0);
                tick();
            end
        end
        ce = 1'b1;

        // Idle timeout with no steps.
        repeat (IT + 10) tick();
        check("idle_moving", 32'(moving), 0);

        // Reset in the middle of a filter run.
        cur = (cur + 1) % 4;
        set_ab(gval[cur]);
        repeat (4) tick();
        Reset_n = 1'b0;
        tick();
        check("rst_pos", 32'(pos), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_moving", 32'(moving), 0);
        check("rst_dir", 32'(dir), 0);
        Reset_n = 1'b1;
        repeat (5) tick();

        // Randomized segments: random code, hold, ce duty, clr and rare resets.
        for (int seg = 0; seg < 600; seg++) begin
            set_ab(int'($urandom_range(0, 3)));
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) begin
                ce      = ($urandom_range(0, 3) != 0);
                clr     = ($urandom_range(0, 49) == 0);
                Reset_n = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        Reset_n = 1'b1; clr = 1'b0; ce = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
